fmul_scheduler: RTL and testbench
=================================

Name: fmul_scheduler

Overview:
- Shares one instance of the 3-stage 24-bit float multiply datapath between two requesters. The datapath is the exponent adder, mantissa multiplier and sign stage, followed by the normaliser.
- Arbitrates round-robin, registers operands into the datapath, and tracks in-flight operations with tags.
- Realigns the exception flags and buffers results in an output FIFO. The datapath has no stall, so acceptance is gated by credits.
- Number format: bit 23 sign, [22:16] exponent (offset 63), [15:0] fraction with hidden 1.

Parameters:
- DEPTH, 4, output FIFO entries; also the initial credit count (min 1, max 15).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a  in  24  requester 0 operand A
- req0_b  in  24  requester 0 operand B
- req1_valid  in  1  requester 1 has an operation
- req1_ready  out  1  requester 1 operation accepted this cycle
- req1_a  in  24  requester 1 operand A
- req1_b  in  24  requester 1 operand B
- dp_op_a  out  24  registered operand A to datapath (sign, exp, frac split by wiring)
- dp_op_b  out  24  registered operand B to datapath
- dp_res  in  24  {sign, normalised exp, normalised frac} from datapath stage 2
- dp_add_uf  in  1  adder underflow (stage 1)
- dp_add_of  in  1  adder overflow (stage 1)
- dp_norm_of  in  1  normaliser overflow (stage 2)
- res_valid  out  1  FIFO head valid
- res_ready  in  1  consumer takes head
- res_data  out  24  product
- res_tag  out  1  originating requester
- res_flags  out  2  {overflow, underflow}
- busy  out  1  any op in flight or buffered

Behaviour:
- Reset (async, active-high) state:
  - dp_op_a = dp_op_b = 0, all pipeline valids 0, FIFO empty.
  - credits = DEPTH, rr_last = 1 (requester 0 wins the first tie).
  - Outputs: res_valid = 0, res_data = 0, res_tag = 0, res_flags = 0, busy = 0.
- Arbitration (combinational):
  - Grant goes to the only valid requester.
  - If both are valid, grant goes to the requester != rr_last.
  - reqN_ready = grantN && (credits != 0). Ready may depend on valid.
  - rr_last updates to the accepted index only on a handshake.
- Accept at edge E0 (valid && ready):
  - dp_op_a/dp_op_b load the granted operands.
  - Tracking shift register v0/t0 <= 1/tag.
  - With no accept: v0 <= 0 and operands hold their value. The datapath still computes; the result is discarded.
- Tracking pipeline: v1/t1 <= v0/t0 at E1 (datapath stage 1 captures); v2/t2 <= v1/t1 at E2 (normaliser captures).
- Flag alignment: dp_add_uf/dp_add_of are sampled at E2 into 1-cycle delay registers so they align with the dp_res/dp_norm_of visible after E2.
  - overflow = delayed dp_add_of | dp_norm_of.
  - underflow = delayed dp_add_uf.
- FIFO write: if v2, push {dp_res, t2, flags} at E3.
  - Acceptance-to-res_valid latency is 3 cycles when the FIFO is empty (res_valid high after E3).
  - Throughput is 1 op/cycle.
- FIFO pop: on res_valid && res_ready. Push and pop in the same cycle on a non-empty FIFO keeps occupancy unchanged. An empty FIFO never bypasses: res_valid rises only after a push.
- Credits:
  - Decrement on accept, increment on pop; both in the same cycle leave credits unchanged.
  - credits + in-flight + occupancy == DEPTH always. This guarantees the FIFO never overflows.
  - At credits = 0 both readies are low; valids are ignored and nothing is lost.
- Data: res_data is passed through as the datapath produced it. Zero, denormal and inf operands get no special handling, and there is no saturation on flags.
- Order: results leave in acceptance order regardless of tag.
- busy = v0 | v1 | v2 | FIFO non-empty.
- Reset mid-operation: all in-flight results are dropped, credits restore to DEPTH, and no result is emitted after reset.

Test Plan:
- Single op, requester 0 issues 0x3F8000 * 0x3F8000 (1.5 * 1.5), res_ready = 1 → 3 cycles later res_valid = 1, res_data = 0x402000, res_tag = 0, res_flags = 00, busy low the cycle after the pop.
- Both requesters valid every cycle: req0 0x400000 * 0xC00000, req1 0x3F0000 * 0x3F0000 → grants alternate 0, 1, 0, 1. Results alternate 0xC10000 tag 0 and 0x3F0000 tag 1, one per cycle.
- Flags: 0x7F0000 * 0x7F0000 → res_flags = 10. 0x010000 * 0x010000 → res_flags = 01. Each flag is attached to the correct result when sent back to back with a clean op (00).
- Backpressure, DEPTH = 4, res_ready = 0, req0 always valid → exactly 4 accepts, then req0_ready = 0. Raising res_ready for 1 cycle gives exactly one further accept. Data order is preserved and there is no overflow.
- Simultaneous accept and pop at credits = 1 → credits stay at 1, occupancy is constant, no gap in ready.
- Assert rst with 3 ops in flight and 2 buffered → res_valid drops immediately, credits = 4, and no stale result appears in the following 5 cycles.

Source files
------------

// File: rtl/fmul_scheduler.sv
// Two-requester front end for a shared 3-stage float multiply datapath: round-robin arbitration,
// tag tracking, exception-flag realignment and a credit-guarded result FIFO.
module fmul_scheduler #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [23:0] req0_a,
    input  logic [23:0] req0_b,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [23:0] req1_a,
    input  logic [23:0] req1_b,
    output logic [23:0] dp_op_a,
    output logic [23:0] dp_op_b,
    input  logic [23:0] dp_res,
    input  logic        dp_add_uf,
    input  logic        dp_add_of,
    input  logic        dp_norm_of,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [23:0] res_data,
    output logic        res_tag,
    output logic [1:0]  res_flags,
    output logic        busy
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EntW = 27;

    // Arbitration and tracking state
    logic [23:0]     op_a_q, op_a_d;
    logic [23:0]     op_b_q, op_b_d;
    logic            rr_last_q, rr_last_d;
    logic [CntW-1:0] credits_q, credits_d;
    logic            v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
    logic            t0_q, t0_d, t1_q, t1_d, t2_q, t2_d;
    logic            add_uf_q, add_uf_d;
    logic            add_of_q, add_of_d;

    // Result FIFO state
    logic [EntW-1:0] mem_q [DEPTH];
    logic [EntW-1:0] mem_d [DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;

    logic            grant0, grant1;
    logic            has_credit;
    logic            acc0, acc1, accept;
    logic            push, pop;
    logic            ovf, unf;
    logic [EntW-1:0] wr_entry;
    logic [EntW-1:0] head;

    always_comb begin
        grant0     = req0_valid && (!req1_valid || rr_last_q);
        grant1     = req1_valid && (!req0_valid || !rr_last_q);
        has_credit = (credits_q != '0);
        req0_ready = grant0 && has_credit;
        req1_ready = grant1 && has_credit;
        acc0       = req0_valid && req0_ready;
        acc1       = req1_valid && req1_ready;
        accept     = acc0 || acc1;
    end

    always_comb begin
        res_valid = (count_q != '0);
        push      = v2_q;
        pop       = res_valid && res_ready;
        // Stage-1 flags were delayed one cycle so they line up with the normaliser output.
        ovf       = add_of_q | dp_norm_of;
        unf       = add_uf_q;
        wr_entry  = {dp_res, t2_q, ovf, unf};
        head      = mem_q[rd_ptr_q];
        res_data  = res_valid ? head[26:3] : '0;
        res_tag   = res_valid ? head[2] : 1'b0;
        res_flags = res_valid ? head[1:0] : 2'b00;
        busy      = v0_q | v1_q | v2_q | res_valid;
        dp_op_a   = op_a_q;
        dp_op_b   = op_b_q;
    end

    always_comb begin
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        rr_last_d = rr_last_q;
        if (acc0) begin
            op_a_d    = req0_a;
            op_b_d    = req0_b;
            rr_last_d = 1'b0;
        end else if (acc1) begin
            op_a_d    = req1_a;
            op_b_d    = req1_b;
            rr_last_d = 1'b1;
        end

        v0_d     = accept;
        t0_d     = acc1;
        v1_d     = v0_q;
        t1_d     = t0_q;
        v2_d     = v1_q;
        t2_d     = t1_q;
        add_uf_d = dp_add_uf;
        add_of_d = dp_add_of;

        unique case ({accept, pop})
            2'b10:   credits_d = credits_q - CntW'(1);
            2'b01:   credits_d = credits_q + CntW'(1);
            default: credits_d = credits_q;
        endcase
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a_q    <= '0;
            op_b_q    <= '0;
            rr_last_q <= 1'b1;
            credits_q <= CntW'(DEPTH);
            v0_q      <= 1'b0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            t0_q      <= 1'b0;
            t1_q      <= 1'b0;
            t2_q      <= 1'b0;
            add_uf_q  <= 1'b0;
            add_of_q  <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            rr_last_q <= rr_last_d;
            credits_q <= credits_d;
            v0_q      <= v0_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            t0_q      <= t0_d;
            t1_q      <= t1_d;
            t2_q      <= t2_d;
            add_uf_q  <= add_uf_d;
            add_of_q  <= add_of_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            mem_q     <= mem_d;
        end
    end

endmodule

// File: tb/tb_fmul_scheduler.sv
// Directed bench for fmul_scheduler with a behavioural 3-stage multiply datapath attached.
module tb_fmul_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic        req0_ready, req1_ready;
    logic [23:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic [23:0] dp_op_a, dp_op_b, dp_res;
    logic        dp_add_uf, dp_add_of, dp_norm_of;
    logic        res_valid, res_tag, busy;
    logic        res_ready = 1'b0;
    logic [23:0] res_data;
    logic [1:0]  res_flags;

    int n_checks = 0;
    int n_errors = 0;

    fmul_scheduler #(.DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .dp_op_a    (dp_op_a),
        .dp_op_b    (dp_op_b),
        .dp_res     (dp_res),
        .dp_add_uf  (dp_add_uf),
        .dp_add_of  (dp_add_of),
        .dp_norm_of (dp_norm_of),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_tag    (res_tag),
        .res_flags  (res_flags),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Datapath: stage 1 = sign/exponent add/mantissa product, stage 2 = normaliser.
    logic        s1_sign = 1'b0;
    int          s1_exp = 0;
    logic [33:0] s1_prod = '0;
    logic [23:0] s2_res = '0;
    logic        s2_nof = 1'b0;

    always @(posedge clk) begin
        s1_sign <= dp_op_a[23] ^ dp_op_b[23];
        s1_exp  <= int'(dp_op_a[22:16]) + int'(dp_op_b[22:16]) - 63;
        s1_prod <= {17'b0, 1'b1, dp_op_a[15:0]} * {17'b0, 1'b1, dp_op_b[15:0]};
        if (s1_prod[33]) begin
            s2_res <= {s1_sign, 7'(s1_exp + 1), s1_prod[32:17]};
            s2_nof <= (s1_exp == 127);
        end else begin
            s2_res <= {s1_sign, 7'(s1_exp), s1_prod[31:16]};
            s2_nof <= 1'b0;
        end
    end

    assign dp_add_of  = (s1_exp > 127);
    assign dp_add_uf  = (s1_exp < 0);
    assign dp_res     = s2_res;
    assign dp_norm_of = s2_nof;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        res_ready  = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [23:0] pow2(input int i);
        return 24'h3F0000 + (24'(i) << 16);
    endfunction

    logic [23:0] fa [4];
    logic [23:0] fb [4];
    logic [1:0]  fexp [4];
    int          acc;

    initial begin
        // Reset values
        #2;
        check_eq("rst_res_valid", 32'(res_valid), 0);
        check_eq("rst_res_data", 32'(res_data), 0);
        check_eq("rst_res_tag", 32'(res_tag), 0);
        check_eq("rst_res_flags", 32'(res_flags), 0);
        check_eq("rst_busy", 32'(busy), 0);
        tick();
        rst = 1'b0;

        // Single op: 1.5 * 1.5, three-cycle latency
        req0_valid = 1'b1;
        req0_a = 24'h3F8000;
        req0_b = 24'h3F8000;
        res_ready = 1'b1;
        #1;
        check_eq("single_ready0", 32'(req0_ready), 1);
        check_eq("single_ready1", 32'(req1_ready), 0);
        tick();
        req0_valid = 1'b0;
        check_eq("single_busy", 32'(busy), 1);
        check_eq("single_lat_e0", 32'(res_valid), 0);
        tick();
        check_eq("single_lat_e1", 32'(res_valid), 0);
        tick();
        check_eq("single_lat_e2", 32'(res_valid), 0);
        tick();
        check_eq("single_valid", 32'(res_valid), 1);
        check_eq("single_data", 32'(res_data), 32'h402000);
        check_eq("single_tag", 32'(res_tag), 0);
        check_eq("single_flags", 32'(res_flags), 0);
        tick();
        check_eq("single_valid_after_pop", 32'(res_valid), 0);
        check_eq("single_busy_after_pop", 32'(busy), 0);

        // Round-robin with both requesters valid
        do_reset();
        res_ready = 1'b1;
        req0_valid = 1'b1;
        req0_a = 24'h400000;
        req0_b = 24'hC00000;
        req1_valid = 1'b1;
        req1_a = 24'h3F0000;
        req1_b = 24'h3F0000;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq($sformatf("rr_ready0_%0d", k), 32'(req0_ready), 32'(k % 2 == 0));
            check_eq($sformatf("rr_ready1_%0d", k), 32'(req1_ready), 32'(k % 2 == 1));
            tick();
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("rr_valid_%0d", k), 32'(res_valid), 1);
            check_eq($sformatf("rr_data_%0d", k), 32'(res_data),
                     (k % 2 == 0) ? 32'hC10000 : 32'h3F0000);
            check_eq($sformatf("rr_tag_%0d", k), 32'(res_tag), 32'(k % 2));
            tick();
        end
        check_eq("rr_drained", 32'(res_valid), 0);

        // Flags back to back with clean ops
        do_reset();
        res_ready = 1'b1;
        fa[0] = 24'h7F0000; fb[0] = 24'h7F0000; fexp[0] = 2'b10;
        fa[1] = 24'h3F8000; fb[1] = 24'h3F8000; fexp[1] = 2'b00;
        fa[2] = 24'h010000; fb[2] = 24'h010000; fexp[2] = 2'b01;
        fa[3] = 24'h7F8000; fb[3] = 24'h3F8000; fexp[3] = 2'b10;
        req0_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            req0_a = fa[k];
            req0_b = fb[k];
            #1;
            check_eq($sformatf("flag_ready_%0d", k), 32'(req0_ready), 1);
            tick();
        end
        req0_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check_eq($sformatf("flag_valid_%0d", k), 32'(res_valid), 1);
            check_eq($sformatf("flag_flags_%0d", k), 32'(res_flags), 32'(fexp[k]));
            if (k == 1) check_eq("flag_clean_data", 32'(res_data), 32'h402000);
            tick();
        end

        // Backpressure: credits cap accepts at DEPTH
        do_reset();
        req0_valid = 1'b1;
        req0_b = 24'h3F0000;
        acc = 0;
        for (int k = 0; k < 8; k++) begin
            req0_a = pow2(acc);
            #1;
            if (req0_ready) acc++;
            tick();
        end
        check_eq("bp_accepts", 32'(acc), 4);
        check_eq("bp_ready_low", 32'(req0_ready), 0);
        check_eq("bp_head", 32'(res_data), 32'(pow2(0)));
        res_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            req0_a = pow2(acc);
            #1;
            if (req0_ready) acc++;
            tick();
            if (k == 0) res_ready = 1'b0;
        end
        check_eq("bp_one_more", 32'(acc), 5);
        req0_valid = 1'b0;
        res_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            check_eq($sformatf("bp_valid_%0d", k), 32'(res_valid), 1);
            check_eq($sformatf("bp_data_%0d", k), 32'(res_data), 32'(pow2(k)));
            tick();
        end
        check_eq("bp_empty", 32'(res_valid), 0);
        check_eq("bp_idle", 32'(busy), 0);

        // Accept and pop together at credits = 1
        do_reset();
        req0_valid = 1'b1;
        req0_b = 24'h3F0000;
        for (int k = 0; k < 3; k++) begin
            req0_a = pow2(k);
            tick();
        end
        req0_valid = 1'b0;
        repeat (4) tick();
        req0_valid = 1'b1;
        res_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req0_a = pow2(3 + k);
            #1;
            check_eq($sformatf("c1_ready_%0d", k), 32'(req0_ready), 1);
            check_eq($sformatf("c1_valid_%0d", k), 32'(res_valid), 1);
            check_eq($sformatf("c1_data_%0d", k), 32'(res_data), 32'(pow2(k)));
            tick();
        end
        req0_valid = 1'b0;

        // Reset with 3 in flight and 2 buffered
        do_reset();
        req0_valid = 1'b1;
        req0_b = 24'h3F0000;
        req0_a = pow2(0);
        tick();
        req0_a = pow2(1);
        tick();
        req0_valid = 1'b0;
        repeat (3) tick();
        req0_valid = 1'b1;
        for (int k = 2; k < 5; k++) begin
            req0_a = pow2(k);
            tick();
        end
        req0_valid = 1'b0;
        check_eq("mr_pre_valid", 32'(res_valid), 1);
        rst = 1'b1;
        #1;
        check_eq("mr_valid_drop", 32'(res_valid), 0);
        check_eq("mr_busy_drop", 32'(busy), 0);
        check_eq("mr_data_zero", 32'(res_data), 0);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_eq($sformatf("mr_no_stale_%0d", k), 32'(res_valid), 0);
        end
        req0_valid = 1'b1;
        acc = 0;
        for (int k = 0; k < 7; k++) begin
            req0_a = pow2(k);
            #1;
            if (req0_ready) acc++;
            tick();
        end
        req0_valid = 1'b0;
        check_eq("mr_credits", 32'(acc), 4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
